// File: rtl/fetch_stage.sv
// RV32 instruction fetch stage with IF/ID pipeline register and a one-entry skid buffer.
// Owns the PC, runs a req/ack handshake to instruction memory and squashes fetches on redirect.
module fetch_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);

  typedef enum logic [1:0] {
    ST_REQ  = 2'b00,
    ST_IDLE = 2'b01,
    ST_DROP = 2'b10
  } state_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

  state_t          state_r, state_s;
  logic [XLEN-1:0] pc_r, pc_s;
  logic [XLEN-1:0] tgt_r, tgt_s;
  logic            skid_valid_r, skid_valid_s;
  logic [31:0]     skid_instr_r, skid_instr_s;
  logic [XLEN-1:0] skid_pc_r, skid_pc_s;
  logic            if_valid_s;
  logic [31:0]     if_instr_s;
  logic [XLEN-1:0] if_pc_s, if_pc_plus4_s;
  logic            out_free_s;
  logic            ack_take_s;

  // In DROP the bus keeps showing the squashed address until its ack arrives.
  assign imem_req   = !rst && ((state_r == ST_REQ) || (state_r == ST_DROP));
  assign imem_addr  = pc_r;
  assign out_free_s = !if_valid || !stall;
  assign ack_take_s = imem_req && imem_ack;

  // Next-state, PC, skid and IF/ID register update.
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    tgt_s         = tgt_r;
    skid_valid_s  = skid_valid_r;
    skid_instr_s  = skid_instr_r;
    skid_pc_s     = skid_pc_r;
    if_valid_s    = if_valid;
    if_instr_s    = if_instr;
    if_pc_s       = if_pc;
    if_pc_plus4_s = if_pc_plus4;

    if (redirect_valid) begin
      if_valid_s   = 1'b0;
      if_instr_s   = NOP_INSTR;
      skid_valid_s = 1'b0;
      if (imem_req && !imem_ack) begin
        state_s = ST_DROP;
        tgt_s   = word_align(redirect_pc);
      end else begin
        state_s = ST_REQ;
        pc_s    = word_align(redirect_pc);
      end
    end else begin
      case (state_r)
        ST_REQ: begin
          // Skid content is older than any new ack, so it drains first.
          if (out_free_s) begin
            if (skid_valid_r) begin
              if_valid_s    = 1'b1;
              if_instr_s    = skid_instr_r;
              if_pc_s       = skid_pc_r;
              if_pc_plus4_s = skid_pc_r + PC_STEP;
              skid_valid_s  = 1'b0;
            end else if (ack_take_s) begin
              if_valid_s    = 1'b1;
              if_instr_s    = imem_rdata;
              if_pc_s       = pc_r;
              if_pc_plus4_s = pc_r + PC_STEP;
            end else begin
              if_valid_s = 1'b0;
              if_instr_s = NOP_INSTR;
            end
          end else begin
            if_valid_s = if_valid;
          end
          if (ack_take_s) begin
            pc_s = pc_r + PC_STEP;
            if (!out_free_s || skid_valid_r) begin
              skid_valid_s = 1'b1;
              skid_instr_s = imem_rdata;
              skid_pc_s    = pc_r;
              state_s      = ST_IDLE;
            end else begin
              state_s = ST_REQ;
            end
          end else begin
            state_s = ST_REQ;
          end
        end
        ST_IDLE: begin
          if (out_free_s) begin
            if_valid_s    = 1'b1;
            if_instr_s    = skid_instr_r;
            if_pc_s       = skid_pc_r;
            if_pc_plus4_s = skid_pc_r + PC_STEP;
            skid_valid_s  = 1'b0;
            state_s       = ST_REQ;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_DROP: begin
          if (out_free_s) begin
            if_valid_s = 1'b0;
            if_instr_s = NOP_INSTR;
          end else begin
            if_valid_s = if_valid;
          end
          if (ack_take_s) begin
            pc_s    = tgt_r;
            state_s = ST_REQ;
          end else begin
            state_s = ST_DROP;
          end
        end
        default: begin
          state_s = ST_REQ;
        end
      endcase
    end
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_REQ;
      pc_r         <= RESET_PC;
      tgt_r        <= RESET_PC;
      skid_valid_r <= 1'b0;
      skid_instr_r <= NOP_INSTR;
      skid_pc_r    <= RESET_PC;
      if_valid     <= 1'b0;
      if_instr     <= NOP_INSTR;
      if_pc        <= RESET_PC;
      if_pc_plus4  <= RESET_PC + PC_STEP;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      tgt_r        <= tgt_s;
      skid_valid_r <= skid_valid_s;
      skid_instr_r <= skid_instr_s;
      skid_pc_r    <= skid_pc_s;
      if_valid     <= if_valid_s;
      if_instr     <= if_instr_s;
      if_pc        <= if_pc_s;
      if_pc_plus4  <= if_pc_plus4_s;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a random-latency memory and a queue model of
// in-order delivery; a negedge monitor compares the IF/ID outputs against the queue.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'hFFFF_FFFC;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  always #5 clk = ~clk;

  fetch_stage #(.XLEN(32), .RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          tag;
  } item_t;

  item_t       q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          wait_cnt = -1;
  int          mem_lat = 0;
  logic [31:0] exp_addr;
  logic [31:0] drop_addr;
  bit          drop_mode = 1'b0;
  bit          exp_req;
  bit          ack;
  bit          mon_ev;
  bit          last_rst = 1'b1;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[17:2]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // One clock: drive inputs, play memory, update the reference model for the coming edge.
  task automatic step(input bit st, input bit rv, input logic [31:0] rpc, input bit r);
    @(posedge clk);
    cyc++;
    #2;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    rst            = r;
    #1;
    // Fetch is wanted unless the output + skid hold two undelivered words.
    exp_req = !r && (drop_mode || (q.size() < 2));
    check("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) check("imem_addr", imem_addr, drop_mode ? drop_addr : exp_addr);

    ack = 1'b0;
    if (imem_req) begin
      if (wait_cnt < 0) wait_cnt = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
      if (wait_cnt == 0) begin
        ack = 1'b1;
        wait_cnt = -1;
      end else begin
        wait_cnt--;
      end
    end else begin
      wait_cnt = -1;
    end
    imem_ack   = ack;
    imem_rdata = ack ? memf(imem_addr) : $urandom();

    if (r) begin
      exp_addr  = RESET_PC;
      drop_mode = 1'b0;
    end else if (rv) begin
      if (exp_req && !ack) begin
        if (!drop_mode) drop_addr = exp_addr;
        drop_mode = 1'b1;
      end else begin
        drop_mode = 1'b0;
      end
      exp_addr = {rpc[31:2], 2'b00};
    end else if (ack) begin
      if (drop_mode) begin
        drop_mode = 1'b0;
      end else begin
        q.push_back('{pc: exp_addr, instr: memf(exp_addr), tag: cyc + 1});
        exp_addr = exp_addr + 32'd4;
      end
    end
  endtask

  // Monitor: compare visible outputs with the oldest undelivered word, then retire it.
  always @(negedge clk) begin
    mon_ev = (q.size() > 0) && (q[0].tag <= cyc);
    check("if_valid", 32'(if_valid), 32'(mon_ev));
    if (mon_ev) begin
      check("if_instr", if_instr, q[0].instr);
      check("if_pc", if_pc, q[0].pc);
      check("if_pc_plus4", if_pc_plus4, q[0].pc + 32'd4);
    end else begin
      check("if_instr_nop", if_instr, NOP);
    end
    if (last_rst) begin
      check("reset_if_pc", if_pc, RESET_PC);
      check("reset_if_pc_plus4", if_pc_plus4, RESET_PC + 32'd4);
    end
    if (rst || redirect_valid) begin
      q.delete();
    end else if (mon_ev && !stall) begin
      void'(q.pop_front());
    end
    last_rst = rst;
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0; exp_addr = RESET_PC; drop_addr = RESET_PC;

    repeat (2) step(1'b0, 1'b0, 32'h0, 1'b1);
    // zero-wait streaming across the address wrap
    repeat (20) step(1'b0, 1'b0, 32'h0, 1'b0);
    // 3-cycle stall fills the skid, then drains in order
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b0);
    // redirect while idle with a full skid, under stall
    repeat (2) step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 32'h0000_0103, 1'b0);
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b0);
    // slow memory, redirect mid-request, then retarget while dropping
    mem_lat = 3;
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h0000_2000, 1'b0);
    step(1'b0, 1'b1, 32'h0000_3006, 1'b0);
    repeat (12) step(1'b0, 1'b0, 32'h0, 1'b0);
    // redirect coincident with ack and stall
    mem_lat = 0;
    repeat (5) step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 32'h0000_4000, 1'b0);
    repeat (5) step(1'b0, 1'b0, 32'h0, 1'b0);
    // reset in the middle of a stall
    repeat (2) step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (5) step(1'b0, 1'b0, 32'h0, 1'b0);
    // randomized traffic
    mem_lat = -1;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
      step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 5, rpc, $urandom_range(0, 199) == 0);
    end
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
